// File: rtl/onchip_rd_pkg.sv
// Shared types and default sizes for the on-chip memory stream reader.
// Holds the reader FSM state encoding and the fixed memory read latency.
package onchip_rd_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 15;
  localparam int MEM_DEPTH_DEF  = 25000;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W          = 16;
  localparam int MEM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/mem_rd_fifo.sv
// First-word-fall-through FIFO: the head entry is visible whenever valid_o is high.
// Push and pop may happen in the same cycle; the reader's credit logic prevents overflow.
module mem_rd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(do_pop);
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by count_q alone, so a flush only clears pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that streams a block of on-chip memory words out as an Avalon-ST source.
// Reads are issued only when the FIFO can hold every word already in flight plus the new one.
module onchip_mem_stream_reader
  import onchip_rd_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipsel,
  output logic              mem_write,
  output logic [3:0]        mem_byteen,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_e             state_q;
  logic               busy_q, done_q, chipsel_q;
  logic               rvalid_q, rd_sop_q, rd_eop_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   count_q, issued_q;

  logic [DATA_W+1:0]  fifo_head;
  logic               fifo_valid;
  logic [CW-1:0]      fifo_count;

  logic               pop, last_pop, issue_d;
  logic [CW-1:0]      fifo_count_d;
  logic [CNT_W-1:0]   issued_d;
  logic [ADDR_W-1:0]  addr_next, base_clamped;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pop          = fifo_valid & out_ready;
    last_pop     = pop & fifo_head[DATA_W+1];
    fifo_count_d = fifo_count + CW'(rvalid_q) - CW'(pop);
    issued_d     = issued_q + CNT_W'(chipsel_q);
    addr_next    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    base_clamped = (int'(base_addr) >= MEM_DEPTH) ? '0 : base_addr;
    // Words still owed to the FIFO after this edge, plus the next issue, must fit.
    issue_d      = (state_q == RUN) && (issued_d < count_q) &&
                   (({1'b0, fifo_count_d} + (CW+1)'(chipsel_q)) < (CW+1)'(FIFO_DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      chipsel_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_sop_q  <= 1'b0;
      rd_eop_q  <= 1'b0;
      addr_q    <= '0;
      count_q   <= '0;
      issued_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      rvalid_q <= chipsel_q;
      rd_sop_q <= (issued_q == '0);
      rd_eop_q <= (issued_q == count_q - CNT_W'(1));
      case (state_q)
        IDLE: begin
          chipsel_q <= 1'b0;
          if (start) begin
            count_q  <= word_count;
            issued_q <= '0;
            if (word_count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              chipsel_q <= 1'b1;
              addr_q    <= base_clamped;
            end
          end
        end
        RUN: begin
          if (chipsel_q) addr_q <= addr_next;
          issued_q  <= issued_d;
          chipsel_q <= issue_d;
          if (issued_d == count_q) state_q <= DRAIN;
        end
        DRAIN: begin
          chipsel_q <= 1'b0;
          if (last_pop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_rd_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (rvalid_q),
    .push_data_i ({rd_eop_q, rd_sop_q, mem_rdata}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_address = addr_q;
  assign mem_chipsel = chipsel_q;
  assign mem_write   = 1'b0;
  assign mem_byteen  = 4'hF;
  assign mem_clken   = 1'b1;
  assign out_valid   = fifo_valid;
  assign out_data    = fifo_valid ? fifo_head[DATA_W-1:0] : '0;
  assign out_sop     = fifo_valid & fifo_head[DATA_W];
  assign out_eop     = fifo_valid & fifo_head[DATA_W+1];

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench for onchip_mem_stream_reader: directed transfers push expected addresses and
// beats into queues, and a negedge monitor pops and compares whatever the DUT presents.
module tb_onchip_mem_stream_reader;

  localparam int MEM_DEPTH = 25000;
  localparam int FDEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done;
  logic [14:0] mem_address;
  logic        mem_chipsel, mem_write, mem_clken;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_sop, out_eop;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] addr_q [$];
  logic [33:0] beat_q [$];
  int          issued_n, popped_n, max_occ, done_seen;
  bit          stall_prev;
  logic [33:0] held;
  bit          ready_toggle = 1'b0;

  onchip_mem_stream_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_chipsel (mem_chipsel),
    .mem_write   (mem_write),
    .mem_byteen  (mem_byteen),
    .mem_clken   (mem_clken),
    .mem_rdata   (mem_rdata),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sop     (out_sop),
    .out_eop     (out_eop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [14:0] a);
    return {2'b10, a, ~a};
  endfunction

  // Memory model: readdata valid the cycle after an issue, junk otherwise.
  always @(posedge clk) mem_rdata <= mem_chipsel ? mem_word(mem_address) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    #2;
    if (ready_toggle) out_ready = ~out_ready;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every issue address and every transferred beat against the queues.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (mem_chipsel) begin
        issued_n++;
        if (addr_q.size() == 0) check("stray_issue", 64'(mem_chipsel), 64'd0);
        else                    check("issue_addr", 64'(mem_address), 64'(addr_q.pop_front()));
      end
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_beat", 64'({out_data, out_sop, out_eop}), 64'(held));
      end
      if (out_valid && out_ready) begin
        popped_n++;
        if (beat_q.size() == 0) check("stray_beat", 64'(out_valid), 64'd0);
        else                    check("beat", 64'({out_data, out_sop, out_eop}), 64'(beat_q.pop_front()));
      end
      stall_prev = out_valid & ~out_ready;
      held       = {out_data, out_sop, out_eop};
      if (issued_n - popped_n > max_occ) max_occ = issued_n - popped_n;
      if (done) done_seen++;
    end
  end

  // Reference model: clamp the base, then walk addresses with wrap at MEM_DEPTH.
  task automatic expect_xfer(input logic [14:0] base, input logic [15:0] cnt);
    logic [14:0] a;
    a = (int'(base) >= MEM_DEPTH) ? 15'd0 : base;
    for (int i = 0; i < int'(cnt); i++) begin
      addr_q.push_back(a);
      beat_q.push_back({mem_word(a), i == 0, i == int'(cnt) - 1});
      a = (int'(a) == MEM_DEPTH - 1) ? 15'd0 : a + 15'd1;
    end
  endtask

  // Returns #1 after the edge that samples start.
  task automatic do_start(input logic [14:0] base, input logic [15:0] cnt, input string name);
    issued_n = 0;
    popped_n = 0;
    max_occ  = 0;
    expect_xfer(base, cnt);
    @(negedge clk);
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_busy_after_start"}, 64'(busy), 64'(cnt != 0));
  endtask

  // Latency = edges after the start-sampling edge until done is seen (0: cycle right after start).
  task automatic wait_done(input int exp_lat, input string name);
    int  lat;
    bit  found;
    lat   = 0;
    found = done;
    while (!found && lat < 300) begin
      @(posedge clk);
      #1 lat++;
      found = done;
    end
    check({name, "_done_seen"}, 64'(found), 64'd1);
    if (found) begin
      if (exp_lat >= 0) check({name, "_done_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_busy_low_at_done"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1 check({name, "_done_one_cycle"}, 64'(done), 64'd0);
    end
    check({name, "_addr_q_empty"}, 64'(addr_q.size()), 64'd0);
    check({name, "_beat_q_empty"}, 64'(beat_q.size()), 64'd0);
  endtask

  initial begin
    int snap;
    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 64'({busy, done, mem_chipsel, out_valid, out_sop, out_eop}), 64'd0);
    check("rst_address", 64'(mem_address), 64'd0);
    check("tie_offs", 64'({mem_write, mem_byteen, mem_clken}), 64'b0_1111_1);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: streaming with ready held high; 8 beats, done 10 edges after start.
    do_start(15'h0010, 16'd8, "t1");
    wait_done(10, "t1");
    check("t1_credit_bound", 64'(max_occ <= FDEPTH), 64'd1);

    // 2: ready toggling; credits must saturate at FIFO_DEPTH without loss.
    ready_toggle = 1'b1;
    do_start(15'h0010, 16'd8, "t2");
    wait_done(-1, "t2");
    check("t2_max_credits", 64'(max_occ), 64'(FDEPTH));
    ready_toggle = 1'b0;
    @(negedge clk) out_ready = 1'b1;

    // 3: address wrap 24999 -> 0 -> 1; then an out-of-range base clamps to 0.
    do_start(15'd24999, 16'd3, "t3");
    wait_done(5, "t3");
    do_start(15'd30000, 16'd2, "clamp");
    wait_done(4, "clamp");

    // 4: zero-length transfer, then a single beat carrying sop and eop.
    do_start(15'd7, 16'd0, "t4z");
    wait_done(0, "t4z");
    do_start(15'd9, 16'd1, "t4one");
    wait_done(3, "t4one");

    // 5: a second start mid-transfer must be ignored.
    do_start(15'd100, 16'd6, "t5");
    repeat (3) @(posedge clk);
    @(negedge clk);
    base_addr  = 15'd500;
    word_count = 16'd4;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("t5_busy_kept", 64'(busy), 64'd1);
    wait_done(4, "t5");

    // 6: asynchronous reset while a read is in flight.
    do_start(15'd200, 16'd8, "t6");
    @(posedge clk);
    @(posedge clk);
    #1 snap = done_seen;
    reset_n = 1'b0;
    #1;
    check("t6_rst_outputs", 64'({busy, done, mem_chipsel, out_valid, out_sop, out_eop}), 64'd0);
    check("t6_rst_addr_data", 64'({mem_address, out_data}), 64'd0);
    addr_q.delete();
    beat_q.delete();
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("t6_no_late_beat", 64'(out_valid), 64'd0);
    check("t6_no_done", 64'(done_seen), 64'(snap));
    do_start(15'd5, 16'd4, "t6post");
    wait_done(6, "t6post");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
